// File: rtl/sprite_motion_ctrl_if.sv
// Bundles the per-frame control inputs and the sprite state outputs of
// sprite_motion_ctrl. The master side supplies keys; the slave side
// (the controller) reports position, direction, speed and edge pulses.
interface sprite_motion_ctrl_if #(
  parameter int W  = 10,
  parameter int SW = 3
);
  logic          enable;
  logic [15:0]   key_code;
  logic [W-1:0]  pos_x;
  logic [W-1:0]  pos_y;
  logic [W-1:0]  size;
  logic [2:0]    dir;
  logic [SW-1:0] speed;
  logic          edge_hit;

  modport master (
    output enable, key_code,
    input  pos_x, pos_y, size, dir, speed, edge_hit
  );

  modport slave (
    input  enable, key_code,
    output pos_x, pos_y, size, dir, speed, edge_hit
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Keyboard-driven sprite motion controller, clocked once per video frame.
// A keycode selects a direction; holding it ramps the speed. The motion
// decided on an edge is applied on that same edge, and the configured edge
// rule (bounce / wrap / stop) keeps the sprite centre inside its legal range.
module sprite_motion_ctrl #(
  parameter int          W           = 10,
  parameter int          X_MIN       = 0,
  parameter int          X_MAX       = 639,
  parameter int          Y_MIN       = 0,
  parameter int          Y_MAX       = 479,
  parameter int          X_CENTER    = 320,
  parameter int          Y_CENTER    = 240,
  parameter int          SIZE        = 4,
  parameter int          STEP        = 1,
  parameter int          MAX_SPEED   = 4,
  parameter int          HOLD_FRAMES = 8,
  parameter int          EDGE_MODE   = 0,
  parameter logic [15:0] KEY_UP      = 16'h001A,
  parameter logic [15:0] KEY_DOWN    = 16'h0016,
  parameter logic [15:0] KEY_LEFT    = 16'h0004,
  parameter logic [15:0] KEY_RIGHT   = 16'h0007,
  parameter logic [15:0] KEY_STOP    = 16'h002C
) (
  input  logic                frame_clk,
  input  logic                Reset_n,
  sprite_motion_ctrl_if.slave bus
);

  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  // Two extra bits give a sign and headroom so the candidate position can go
  // below MIN or above MAX without wrapping.
  localparam int DW = W + 2;

  localparam logic signed [DW-1:0] X_LO = DW'(X_MIN + SIZE);
  localparam logic signed [DW-1:0] X_HI = DW'(X_MAX - SIZE);
  localparam logic signed [DW-1:0] Y_LO = DW'(Y_MIN + SIZE);
  localparam logic signed [DW-1:0] Y_HI = DW'(Y_MAX - SIZE);

  localparam logic [SW-1:0] SPEED_MAX = SW'(MAX_SPEED);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    EDGE_BOUNCE = 2'd0,
    EDGE_WRAP   = 2'd1,
    EDGE_STOP   = 2'd2
  } edge_mode_e;

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE);

  dir_e          dir_q, dir_d;
  logic [SW-1:0] speed_q, speed_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [W-1:0]  pos_x_q, pos_x_d;
  logic [W-1:0]  pos_y_q, pos_y_d;
  logic          edge_hit_q, edge_hit_d;

  dir_e                 key_dir;
  logic                 key_is_stop;
  logic                 moving, moving_y, moving_neg;
  logic signed [DW-1:0] cur_pos, delta, cand, new_pos, lim_lo, lim_hi;

  function automatic dir_e reverse_dir(input dir_e d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_IDLE;
    endcase
  endfunction

  // Keycode decode: STOP is flagged separately and checked first, then
  // directions in UP > DOWN > LEFT > RIGHT order.
  always_comb begin
    key_is_stop = (bus.key_code == KEY_STOP);
    key_dir     = DIR_IDLE;
    if (bus.key_code == KEY_UP)         key_dir = DIR_UP;
    else if (bus.key_code == KEY_DOWN)  key_dir = DIR_DOWN;
    else if (bus.key_code == KEY_LEFT)  key_dir = DIR_LEFT;
    else if (bus.key_code == KEY_RIGHT) key_dir = DIR_RIGHT;
  end

  // Next state: key decode first, then movement using the freshly decided
  // direction and speed, then the edge rule on the moving axis.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned, which would otherwise infer a latch.
    dir_d      = dir_q;
    speed_d    = speed_q;
    hcnt_d     = hcnt_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    edge_hit_d = 1'b0;
    moving     = 1'b0;
    moving_y   = 1'b0;
    moving_neg = 1'b0;
    cur_pos    = '0;
    delta      = '0;
    cand       = '0;
    new_pos    = '0;
    lim_lo     = '0;
    lim_hi     = '0;

    if (bus.enable) begin
      if (key_is_stop) begin
        dir_d   = DIR_IDLE;
        speed_d = '0;
        hcnt_d  = '0;
      end else if (key_dir != DIR_IDLE) begin
        if (key_dir != dir_q) begin
          dir_d   = key_dir;
          speed_d = SW'(1);
          hcnt_d  = '0;
        end else if (hcnt_q == HOLD_LAST) begin
          hcnt_d = '0;
          if (speed_q < SPEED_MAX) speed_d = speed_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end else begin
        hcnt_d = '0;
      end

      case (dir_d)
        DIR_UP:    begin moving = 1'b1; moving_y = 1'b1; moving_neg = 1'b1; end
        DIR_DOWN:  begin moving = 1'b1; moving_y = 1'b1; end
        DIR_LEFT:  begin moving = 1'b1; moving_neg = 1'b1; end
        DIR_RIGHT: begin moving = 1'b1; end
        default:   ;
      endcase

      delta   = DW'(int'(speed_d) * STEP);
      cur_pos = moving_y ? $signed({2'b00, pos_y_q}) : $signed({2'b00, pos_x_q});
      lim_lo  = moving_y ? Y_LO : X_LO;
      lim_hi  = moving_y ? Y_HI : X_HI;
      cand    = moving_neg ? (cur_pos - delta) : (cur_pos + delta);
      new_pos = cand;

      if (moving && ((cand < lim_lo) || (cand > lim_hi))) begin
        edge_hit_d = 1'b1;
        case (MODE)
          EDGE_WRAP: new_pos = (cand < lim_lo) ? lim_hi : lim_lo;
          EDGE_STOP: begin
            new_pos = (cand < lim_lo) ? lim_lo : lim_hi;
            dir_d   = DIR_IDLE;
            speed_d = '0;
            hcnt_d  = '0;
          end
          default: begin
            new_pos = (cand < lim_lo) ? lim_lo : lim_hi;
            dir_d   = reverse_dir(dir_d);
          end
        endcase
      end

      if (moving) begin
        if (moving_y) pos_y_d = W'(new_pos);
        else          pos_x_d = W'(new_pos);
      end
    end
  end

  // State registers with asynchronous reset to the centre, idle and still.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    // NOTE: state flops use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!Reset_n) begin
      dir_q      <= DIR_IDLE;
      speed_q    <= '0;
      hcnt_q     <= '0;
      pos_x_q    <= W'(X_CENTER);
      pos_y_q    <= W'(Y_CENTER);
      edge_hit_q <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      speed_q    <= speed_d;
      hcnt_q     <= hcnt_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      edge_hit_q <= edge_hit_d;
    end
  end

  assign bus.pos_x    = pos_x_q;
  assign bus.pos_y    = pos_y_q;
  assign bus.size     = W'(SIZE);
  assign bus.dir      = dir_q;
  assign bus.speed    = speed_q;
  assign bus.edge_hit = edge_hit_q;

endmodule
